care_action_ctrl: RTL

// - Player-side driver of the pet stats block. Debounces two raw push-buttons (NEXT, OK).
// - Runs a menu FSM over the care actions and issues one-cycle decrement pulses on care_pulse[7:0].
// - Generates the pseudo-random stat index stream on random[4:0].
// - Sits between board buttons and the stats block: care_pulse feeds stats.inputs, random feeds stats.random.

---
 rtl/tama_pkg.sv | 35 +++
 rtl/btn_debounce.sv | 59 +++++
 rtl/care_action_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/tama_pkg.sv
// Shared pet-game definitions: stat indices, care FSM encoding and the LFSR step.
// Latency: n/a (types, constants and one pure function).
// Backpressure: n/a.
package tama_pkg;

    localparam int NUM_STATS = 5;

    typedef enum logic [2:0] {
        STAT_HUNGER  = 3'd0,
        STAT_HAPPY   = 3'd1,
        STAT_HEALTH  = 3'd2,
        STAT_HYGIENE = 3'd3,
        STAT_ENERGY  = 3'd4
    } stat_e;

    typedef enum logic [1:0] {
        CARE_IDLE     = 2'd0,
        CARE_PULSE    = 2'd1,
        CARE_COOLDOWN = 2'd2
    } care_state_e;

    // x^16 + x^14 + x^13 + x^11, right-shifting Galois form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur, input logic [15:0] seed);
        logic [15:0] nxt;
        if (cur == 16'd0) begin
            nxt = seed;
        end else begin
            nxt = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'd0);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-FF sync -> level debounce -> one-cycle press on the debounced rising edge.
// Latency: press is high 2 + DEBOUNCE_CYCLES cycles after a clean raw rise.
// Backpressure: none; release edges produce no event.
module btn_debounce
    import tama_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        // Any sample agreeing with the accepted level restarts the hold window.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/care_action_ctrl.sv
// Player-side care driver: debounced NEXT/OK menu, one-hot care pulse with cooldown, LFSR random stream.
// Latency: care_pulse and busy rise the cycle after the OK press; random updates every cycle.
// Backpressure: presses arriving while busy are dropped, never queued.
module care_action_ctrl
    import tama_pkg::*;
#(
    parameter int          NUM_ACTIONS     = NUM_STATS,
    parameter int          DEBOUNCE_CYCLES = 270000,
    parameter int          COOLDOWN_CYCLES = 2700000,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       btn_ok,
    output logic [7:0] care_pulse,
    output logic [4:0] random,
    output logic [2:0] menu_sel,
    output logic       busy
);

    localparam int CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam logic [CD_W-1:0] CD_LAST   = CD_W'(COOLDOWN_CYCLES - 1);
    localparam logic [2:0]      MENU_LAST = 3'(NUM_ACTIONS - 1);
    localparam logic [7:0]      ACT_MASK  = 8'((16'd1 << NUM_ACTIONS) - 16'd1);

    generate
        if (NUM_ACTIONS < 1 || NUM_ACTIONS > 8) begin : g_num_actions_check
            $error("care_action_ctrl: NUM_ACTIONS must be in 1..8");
        end
    endgenerate

    logic press_next;
    logic press_ok;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_next),
        .press   (press_next)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ok (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_ok),
        .press   (press_ok)
    );

    care_state_e     state_q, state_d;
    logic [2:0]      menu_sel_q, menu_sel_d;
    logic [CD_W-1:0] cd_cnt_q, cd_cnt_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [4:0]      random_q, random_d;

    always_comb begin
        state_d    = state_q;
        menu_sel_d = menu_sel_q;
        cd_cnt_d   = cd_cnt_q;
        care_pulse = 8'd0;
        busy       = 1'b1;
        case (state_q)
            CARE_IDLE: begin
                busy = 1'b0;
                // OK wins a same-cycle tie; the NEXT press is simply lost.
                if (press_ok) begin
                    state_d = CARE_PULSE;
                end else if (press_next) begin
                    menu_sel_d = (menu_sel_q == MENU_LAST) ? 3'd0 : menu_sel_q + 3'd1;
                end
            end
            CARE_PULSE: begin
                care_pulse = (8'd1 << menu_sel_q) & ACT_MASK;
                cd_cnt_d   = '0;
                state_d    = CARE_COOLDOWN;
            end
            CARE_COOLDOWN: begin
                if (cd_cnt_q == CD_LAST) begin
                    cd_cnt_d = '0;
                    state_d  = CARE_IDLE;
                end else begin
                    cd_cnt_d = cd_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = CARE_IDLE;
            end
        endcase
    end

    // Free-running; the zero check only matters if an upset ever clears the register.
    always_comb begin
        lfsr_d   = lfsr_step(lfsr_q, LFSR_SEED);
        random_d = lfsr_d[4:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= CARE_IDLE;
            menu_sel_q <= STAT_HUNGER;
            cd_cnt_q   <= '0;
            lfsr_q     <= LFSR_SEED;
            random_q   <= LFSR_SEED[4:0];
        end else begin
            state_q    <= state_d;
            menu_sel_q <= menu_sel_d;
            cd_cnt_q   <= cd_cnt_d;
            lfsr_q     <= lfsr_d;
            random_q   <= random_d;
        end
    end

    assign menu_sel = menu_sel_q;
    assign random   = random_q;

endmodule
